// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared width, state encoding and divide-by-zero constant
package seq_restoring_divider_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - start/done handshake and operand/result bundle
interface seq_restoring_divider_if
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_cla_subtractor.sv
// rtl/seq_restoring_divider_cla_subtractor.sv - a + ~b + 1 built from rippled 4-bit CLA blocks
module cla_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_c_out
);

  localparam int NB = WIDTH / 4;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;

  assign w_g    = i_a & ~i_b;
  assign w_p    = i_a ^ ~i_b;
  assign w_c[0] = 1'b1;

  // Carries inside a block are full lookahead; only the block carry-out ripples.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int B = 4 * k;
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_c[B]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_c[B]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
    assign w_c[B+4] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
  end

  assign o_diff  = w_p ^ w_c[WIDTH-1:0];
  assign o_c_out = w_c[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - restoring shift-subtract divider, one quotient bit per clock
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_restoring_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       r_state, w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q, r_d, r_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient, r_remainder;
  logic             r_done, r_div0;

  logic             w_msb, w_c, w_ok;
  logic [WIDTH-1:0] w_rsh, w_diff;

  assign w_msb = r_r[WIDTH-1];
  assign w_rsh = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  // A set shifted-out msb means the partial remainder already exceeds D.
  assign w_ok  = w_msb | w_c;

  cla_subtractor #(.WIDTH(WIDTH)) u_sub (
    .i_a     (w_rsh),
    .i_b     (r_d),
    .o_diff  (w_diff),
    .o_c_out (w_c)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = (bus.divisor == '0) ? S_DONE : S_RUN;
      S_RUN:  if (r_count == CW'(WIDTH - 1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_div0      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_d     <= bus.divisor;
            r_count <= '0;
            r_div0  <= 1'b0;
            // Zero divisor preloads the fixed result so DONE copies it out unchanged.
            if (bus.divisor == '0) begin
              r_q  <= {WIDTH{1'b1}};
              r_r  <= bus.dividend;
              r_dz <= 1'b1;
            end else begin
              r_q  <= bus.dividend;
              r_r  <= '0;
              r_dz <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_r     <= w_ok ? w_diff : w_rsh;
          r_q     <= {r_q[WIDTH-2:0], w_ok};
          r_count <= r_count + 1'b1;
        end
        S_DONE: begin
          r_quotient  <= r_q;
          r_remainder <= r_r;
          r_div0      <= r_dz;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div0;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - randomized and directed bench against a / and % model
module tb_seq_restoring_divider;
  import seq_restoring_divider_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(16)) bus ();

  seq_restoring_divider #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: divisor 0 yields all-ones quotient and the dividend as remainder.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output int lat);
    if (b == 16'd0) begin
      q = DIV0_QUOTIENT; r = a; dz = 1'b1; lat = 1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = 17;
    end
  endfunction

  // Called at posedge+1; returns in the done cycle (posedge+1).
  task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r, output logic dz,
                        output int lat, output logic seq_err);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dividend = 16'($urandom); bus.divisor = 16'($urandom);
    lat = -1; seq_err = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) begin
        lat = n;
        if (bus.busy !== 1'b0) seq_err = 1'b1;
        break;
      end
      if (bus.busy !== 1'b1) seq_err = 1'b1;
      @(posedge clk); #1;
    end
    q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++;
    if (bus.quotient !== 16'd0) begin n_bad++; $display("FAIL reset_quotient got %h want 0", bus.quotient); end
    n_cmp++;
    if (bus.remainder !== 16'd0) begin n_bad++; $display("FAIL reset_remainder got %h want 0", bus.remainder); end
    n_cmp++;
    if (bus.div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dz got %b want 0", bus.div_by_zero); end
    n_cmp++;
  endtask

  task automatic test_directed();
    logic [15:0] ta [6] = '{16'd40000, 16'd65535, 16'd25937, 16'd1000, 16'd50000, 16'd7};
    logic [15:0] tb [6] = '{16'd900,   16'd1,     16'd7,     16'd2500, 16'd50000, 16'd0};
    logic [15:0] q, r, eq, er;
    logic dz, edz, se;
    int lat, elat;
    for (int i = 0; i < 6; i++) begin
      model(ta[i], tb[i], eq, er, edz, elat);
      do_div(ta[i], tb[i], q, r, dz, lat, se);
      if (q !== eq) begin n_bad++; $display("FAIL dir%0d_quotient got %0d want %0d", i, q, eq); end
      n_cmp++;
      if (r !== er) begin n_bad++; $display("FAIL dir%0d_remainder got %0d want %0d", i, r, er); end
      n_cmp++;
      if (dz !== edz) begin n_bad++; $display("FAIL dir%0d_dz got %b want %b", i, dz, edz); end
      n_cmp++;
      if (lat != elat) begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, elat); end
      n_cmp++;
      if (se !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_seq got %b want 0", i, se); end
      n_cmp++;
    end
  endtask

  task automatic test_ignore_start();
    int got = -1;
    bus.start = 1'b1; bus.dividend = 16'd40000; bus.divisor = 16'd900;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) begin got = n; break; end
      if (n == 5) begin bus.start = 1'b1; bus.dividend = 16'd123; bus.divisor = 16'd0; end
      else bus.start = 1'b0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    if (got != 17) begin n_bad++; $display("FAIL ignore_latency got %0d want 17", got); end
    n_cmp++;
    if (bus.quotient !== 16'd44 || bus.remainder !== 16'd400 || bus.div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_result got %0d/%0d/%b want 44/400/0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    n_cmp++;
    @(posedge clk); #1;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL ignore_after got done=%b busy=%b want 0/0", bus.done, bus.busy);
    end
    n_cmp++;
  endtask

  task automatic test_hold();
    logic [15:0] q, r;
    logic dz, se;
    int lat;
    int got = -1;
    do_div(16'd1000, 16'd0, q, r, dz, lat, se);
    repeat (3) begin @(posedge clk); #1; end
    if (bus.quotient !== 16'hFFFF || bus.remainder !== 16'd1000 || bus.div_by_zero !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_idle got %h/%0d/%b want ffff/1000/1", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    n_cmp++;
    bus.start = 1'b1; bus.dividend = 16'd50000; bus.divisor = 16'd50000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (bus.quotient !== 16'hFFFF || bus.div_by_zero !== 1'b0) begin
      n_bad++; $display("FAIL hold_accept got q=%h dz=%b want ffff/0", bus.quotient, bus.div_by_zero);
    end
    n_cmp++;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) begin got = n; break; end
      @(posedge clk); #1;
    end
    if (got != 17 || bus.quotient !== 16'd1 || bus.remainder !== 16'd0) begin
      n_bad++; $display("FAIL hold_result got lat=%0d q=%0d r=%0d want 17/1/0", got, bus.quotient, bus.remainder);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] q, r;
    logic dz, se;
    int lat;
    bus.start = 1'b1; bus.dividend = 16'd40000; bus.divisor = 16'd900;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 16'd0 ||
        bus.remainder !== 16'd0 || bus.div_by_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_outputs got busy=%b done=%b q=%h r=%h dz=%b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    n_cmp++;
    do_div(16'd25937, 16'd7, q, r, dz, lat, se);
    if (q !== 16'd3705 || r !== 16'd2 || lat != 17 || se !== 1'b0) begin
      n_bad++; $display("FAIL midrst_next got q=%0d r=%0d lat=%0d se=%b want 3705/2/17/0", q, r, lat, se);
    end
    n_cmp++;
  endtask

  task automatic test_held_start();
    int got1 = -1;
    int got2 = -1;
    bus.start = 1'b1; bus.dividend = 16'd12345; bus.divisor = 16'd100;
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) begin got1 = n; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (got1 != 17 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL held_first got lat=%0d busy_next=%b want 17/1", got1, bus.busy);
    end
    n_cmp++;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) begin got2 = n; break; end
      @(posedge clk); #1;
    end
    if (got2 != 17 || bus.quotient !== 16'd123 || bus.remainder !== 16'd45) begin
      n_bad++; $display("FAIL held_second got lat=%0d q=%0d r=%0d want 17/123/45", got2, bus.quotient, bus.remainder);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    logic [15:0] a, b, q, r, eq, er;
    logic dz, edz, se;
    int lat, elat, mode;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 16'd0;
      else if (mode < 4) b = 16'($urandom_range(1, 15));
      else b = 16'($urandom);
      model(a, b, eq, er, edz, elat);
      do_div(a, b, q, r, dz, lat, se);
      if (q !== eq || r !== er || dz !== edz) begin
        n_bad++; $display("FAIL rnd%0d_result %0d/%0d got %0d,%0d,%b want %0d,%0d,%b", i, a, b, q, r, dz, eq, er, edz);
      end
      n_cmp++;
      if (lat != elat || se !== 1'b0) begin
        n_bad++; $display("FAIL rnd%0d_timing %0d/%0d got lat=%0d se=%b want %0d/0", i, a, b, lat, se, elat);
      end
      n_cmp++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_directed();
    test_ignore_start();
    test_hold();
    test_reset_mid();
    test_held_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
